// File: rtl/up_prog_loader_if.sv
// up_prog_loader_if: pin-side nibble stream and RAM/core-side outputs of the
// program loader, bundled so the loader and its environment share one port.
//   load_req, nib_stb, nib_in : asynchronous pin inputs (driven by master)
//   mem_we, mem_addr, mem_wdata : program RAM write port (driven by slave)
//   cpu_run, busy, done, err, byte_count : status (driven by slave)
// The loader itself connects through the slave modport.
interface up_prog_loader_if #(
  parameter int ADDR_W = 5
);
  logic              load_req;
  logic              nib_stb;
  logic [3:0]        nib_in;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_run;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   byte_count;

  modport master (
    output load_req, nib_stb, nib_in,
    input  mem_we, mem_addr, mem_wdata, cpu_run, busy, done, err, byte_count
  );

  modport slave (
    input  load_req, nib_stb, nib_in,
    output mem_we, mem_addr, mem_wdata, cpu_run, busy, done, err, byte_count
  );
endinterface

// File: rtl/up_prog_loader.sv
// up_prog_loader: receives a program image as a nibble stream (high nibble
// first) framed as length byte, data bytes, checksum byte, writes the data
// bytes sequentially into program RAM and keeps the core halted until a
// complete valid image has been loaded.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   ena  : design enable; when low, pin events are discarded and state holds
//   bus  : up_prog_loader_if.slave (pin inputs, RAM write port, status)
// Parameters: ADDR_W (RAM address width, <= 7), DEPTH (max image length,
// <= 2**ADDR_W).
// Build option: define LOADER_CHECKSUM_EN to receive and verify the trailing
// checksum byte; without it the image is accepted right after the last data
// byte and any further nibbles are ignored.
module up_prog_loader #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  up_prog_loader_if.slave   bus
);

  localparam int CW = ADDR_W + 1;
  localparam logic [8:0]        DEPTH_B  = 9'(DEPTH);
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DAT_HI,
    S_DAT_LO,
`ifdef LOADER_CHECKSUM_EN
    S_CHK_HI,
    S_CHK_LO,
`endif
    S_DONE,
    S_ERR
  } state_t;

  // [0],[1] form the 2-FF synchronizer; [2] is the previous synchronized
  // value used for edge detection (capture lands 3 clocks after the pin edge)
  logic [2:0] ld_sync_q;
  logic [2:0] stb_sync_q;
  logic       ld_rise;
  logic       ld_fall;
  logic       stb_ev;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     len_q, len_d;
  logic [CW-1:0]     count_inc;
  logic [3:0]        hi_q, hi_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [7:0]        byte_w;
  logic              busy_w;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d, sum_nxt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_sync_q  <= '0;
      stb_sync_q <= '0;
    end else begin
      ld_sync_q  <= {ld_sync_q[1:0], bus.load_req};
      stb_sync_q <= {stb_sync_q[1:0], bus.nib_stb};
    end
  end

  assign ld_rise = ena &  ld_sync_q[1] & ~ld_sync_q[2];
  assign ld_fall = ena & ~ld_sync_q[1] &  ld_sync_q[2];
  assign stb_ev  = ena &  stb_sync_q[1] & ~stb_sync_q[2];

  always_comb begin
    busy_w = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    waddr_d   = waddr_q;
    count_d   = count_q;
    len_d     = len_q;
    hi_d      = hi_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    byte_w    = {hi_q, bus.nib_in};
    count_inc = count_q + CNT_ONE;
`ifdef LOADER_CHECKSUM_EN
    sum_d     = sum_q;
    sum_nxt   = sum_q + byte_w;
`endif

    // load_req edges take priority over a coincident strobe, which is dropped
    if (ld_rise) begin
      state_d = S_LEN_HI;
      addr_d  = '0;
      count_d = '0;
`ifdef LOADER_CHECKSUM_EN
      sum_d   = '0;
`endif
    end else if (ld_fall && busy_w) begin
      state_d = S_ERR;
    end else if (stb_ev) begin
      case (state_q)
        S_LEN_HI: begin
          hi_d    = bus.nib_in;
          state_d = S_LEN_LO;
        end
        S_LEN_LO: begin
`ifdef LOADER_CHECKSUM_EN
          sum_d = sum_nxt;
`endif
          if ((byte_w == 8'h00) || ({1'b0, byte_w} > DEPTH_B)) begin
            state_d = S_ERR;
          end else begin
            len_d   = byte_w[CW-1:0];
            state_d = S_DAT_HI;
          end
        end
        S_DAT_HI: begin
          hi_d    = bus.nib_in;
          state_d = S_DAT_LO;
        end
        S_DAT_LO: begin
`ifdef LOADER_CHECKSUM_EN
          sum_d = sum_nxt;
`endif
          // write strobe is registered, so it appears the cycle after capture
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = byte_w;
          addr_d  = addr_q + ADDR_ONE;
          count_d = count_inc;
          if (count_inc == len_q) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CHK_HI;
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_DAT_HI;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHK_HI: begin
          hi_d    = bus.nib_in;
          state_d = S_CHK_LO;
        end
        S_CHK_LO: begin
          sum_d   = sum_nxt;
          state_d = (sum_nxt == 8'h00) ? S_DONE : S_ERR;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      waddr_q <= '0;
      count_q <= '0;
      len_q   <= '0;
      hi_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      waddr_q <= waddr_d;
      count_q <= count_d;
      len_q   <= len_d;
      hi_q    <= hi_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = waddr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.busy       = busy_w;
  assign bus.done       = (state_q == S_DONE);
  assign bus.cpu_run    = (state_q == S_DONE);
  assign bus.err        = (state_q == S_ERR);
  assign bus.byte_count = count_q;

endmodule

// File: tb/tb_up_prog_loader.sv
// Directed self-checking bench for up_prog_loader (ADDR_W=5, DEPTH=32).
// Expectations adapt to whether LOADER_CHECKSUM_EN is defined.
module tb_up_prog_loader;

  logic clk;
  logic rst;
  logic ena;

  up_prog_loader_if #(.ADDR_W(5)) bus ();

  up_prog_loader #(.ADDR_W(5), .DEPTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // write log filled by the monitor; only the monitor writes these
  int         wr_n    = 0;
  int         run_len = 0;
  int         max_run = 0;
  int         wr_addr [256];
  logic [7:0] wr_data [256];

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      if (wr_n < 256) begin
        wr_addr[wr_n] = int'(bus.mem_addr);
        wr_data[wr_n] = bus.mem_wdata;
      end
      wr_n    = wr_n + 1;
      run_len = run_len + 1;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // minimum-rate nibble: data 1 cycle before strobe, 2 high, 2 low, held 3 after
  task automatic send_nib(input logic [3:0] n);
    bus.nib_in = n;
    @(negedge clk);
    bus.nib_stb = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.nib_stb = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_nib(b[7:4]);
    send_nib(b[3:0]);
  endtask

  task automatic start_session();
    bus.load_req = 1'b0;
    repeat (4) @(negedge clk);
    bus.load_req = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  logic [7:0] f3 [3];
  logic [7:0] big [32];
  logic [7:0] sum;
  int         base;

  initial begin
    f3[0] = 8'hA9; f3[1] = 8'h05; f3[2] = 8'hF0;
    rst = 1'b1; ena = 1'b1;
    bus.load_req = 1'b0; bus.nib_stb = 1'b0; bus.nib_in = 4'h0;
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_status", {bus.cpu_run, bus.busy, bus.done, bus.err}, 0);
    chk("rst_byte_count", bus.byte_count, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // good frame, with an ena=0 byte injected after the length
    base = wr_n;
    start_session();
    chk("t2_busy_start", bus.busy, 1);
    send_byte(8'h03);
    ena = 1'b0;
    send_byte(8'h77);
    ena = 1'b1;
    chk("t2_ena0_nowrite", wr_n - base, 0);
    chk("t2_ena0_count", bus.byte_count, 0);
    for (int i = 0; i < 3; i++) send_byte(f3[i]);
    send_byte(8'h5F);
    repeat (2) @(negedge clk);
    chk("t2_writes", wr_n - base, 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t2_addr%0d", i), wr_addr[base+i], i);
      chk($sformatf("t2_data%0d", i), wr_data[base+i], f3[i]);
    end
    chk("t2_done", bus.done, 1);
    chk("t2_cpu_run", bus.cpu_run, 1);
    chk("t2_err", bus.err, 0);
    chk("t2_busy", bus.busy, 0);
    chk("t2_byte_count", bus.byte_count, 3);
    chk("t2_mem_addr_last", bus.mem_addr, 2);

    // bad checksum
    base = wr_n;
    start_session();
    send_byte(8'h03);
    for (int i = 0; i < 3; i++) send_byte(f3[i]);
    send_byte(8'h60);
    repeat (2) @(negedge clk);
    chk("t3_writes", wr_n - base, 3);
`ifdef LOADER_CHECKSUM_EN
    chk("t3_status", {bus.cpu_run, bus.done, bus.err}, 3'b001);
`else
    chk("t3_status", {bus.cpu_run, bus.done, bus.err}, 3'b110);
`endif

    // illegal lengths
    base = wr_n;
    start_session();
    send_byte(8'h00);
    @(negedge clk);
    chk("t4_len0_err_busy", {bus.err, bus.busy}, 2'b10);
    chk("t4_len0_nowrite", wr_n - base, 0);
    start_session();
    chk("t4_restart_clears_err", {bus.err, bus.busy}, 2'b01);
    send_byte(8'h21);
    @(negedge clk);
    chk("t4_len21_err_busy", {bus.err, bus.busy}, 2'b10);
    chk("t4_len21_nowrite", wr_n - base, 0);
    chk("t4_len21_cpu_run", bus.cpu_run, 0);

    // early load_req drop after 5 nibbles of a len=4 frame
    base = wr_n;
    start_session();
    send_byte(8'h04);
    send_byte(8'h12);
    send_nib(4'h3);
    bus.load_req = 1'b0;
    repeat (5) @(negedge clk);
    chk("t5_err", bus.err, 1);
    chk("t5_busy", bus.busy, 0);
    chk("t5_byte_count", bus.byte_count, 1);
    chk("t5_writes", wr_n - base, 1);
    chk("t5_wdata", wr_data[base], 8'h12);

    // asynchronous reset mid-stream, then a clean reload
    start_session();
    send_byte(8'h05);
    for (int i = 0; i < 3; i++) send_byte(f3[i]);
    chk("t6_pre_count", bus.byte_count, 3);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_status", {bus.cpu_run, bus.busy, bus.done, bus.err, bus.mem_we}, 0);
    chk("t6_rst_count", bus.byte_count, 0);
    chk("t6_rst_addr", bus.mem_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    base = wr_n;
    start_session();
    send_byte(8'h03);
    for (int i = 0; i < 3; i++) send_byte(f3[i]);
    send_byte(8'h5F);
    repeat (2) @(negedge clk);
    chk("t6_writes", wr_n - base, 3);
    chk("t6_first_addr", wr_addr[base], 0);
    chk("t6_first_data", wr_data[base], 8'hA9);
    chk("t6_done", bus.done, 1);

    // load_req drop in DONE has no effect; then a full-depth reload
    bus.load_req = 1'b0;
    repeat (5) @(negedge clk);
    chk("t7_drop_in_done", {bus.done, bus.err}, 2'b10);
    sum = 8'h20;
    for (int i = 0; i < 32; i++) begin
      big[i] = 8'((i * 37) + 11);
      sum = sum + big[i];
    end
    base = wr_n;
    start_session();
    send_byte(8'h20);
    for (int i = 0; i < 32; i++) send_byte(big[i]);
`ifdef LOADER_CHECKSUM_EN
    chk("t7_after_last_data", {bus.done, bus.busy}, 2'b01);
`else
    chk("t7_after_last_data", {bus.done, bus.busy}, 2'b10);
`endif
    send_byte(8'h00 - sum);
    repeat (2) @(negedge clk);
    chk("t7_writes", wr_n - base, 32);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("t7_addr%0d", i), wr_addr[base+i], i);
      chk($sformatf("t7_data%0d", i), wr_data[base+i], big[i]);
    end
    chk("t7_done", {bus.done, bus.cpu_run, bus.err}, 3'b110);
    chk("t7_byte_count", bus.byte_count, 32);
    chk("t7_mem_addr_last", bus.mem_addr, 31);

    chk("we_pulse_width", max_run, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
